// File: rtl/vend_change_fsm.sv
// Vending controller: accumulates nickel/dime/quarter credit and vends at PRICE.
// Change or a refund is paid out as dime/nickel pulses, with each pulse followed
// by GAP low cycles. All outputs are registered.
module vend_change_fsm #(
  parameter int unsigned PRICE      = 30,
  parameter int unsigned MAX_CREDIT = 95,
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned GAP        = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                refund,
  output logic                vend,
  output logic                nickel_out,
  output logic                dime_out,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] DIME_C   = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(5);
  localparam logic [SUM_W-1:0]    MAX_C    = SUM_W'(MAX_CREDIT);
  localparam logic [3:0]          GAP_C    = 4'(GAP);

  typedef enum logic {
    IDLE,
    CHANGE
  } state_t;

  state_t               state;
  logic [3:0]           gap;
  logic [SUM_W-1:0]     coin_sum;
  logic [SUM_W-1:0]     sum;
  logic                 over;
  logic [CREDIT_W-1:0]  post_credit;
  logic                 any_coin;

  // Value of the coins on this edge. The sum is one bit wider than credit, so the
  // ceiling test cannot wrap.
  always_comb begin
    coin_sum = '0;
    if (nickel)  coin_sum = coin_sum + SUM_W'(5);
    if (dime)    coin_sum = coin_sum + SUM_W'(10);
    if (quarter) coin_sum = coin_sum + SUM_W'(25);
    any_coin    = nickel | dime | quarter;
    sum         = {1'b0, credit} + coin_sum;
    over        = (sum > MAX_C);
    post_credit = over ? credit : sum[CREDIT_W-1:0];
  end

  // Controller state, credit, pacing counter and registered output pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      gap         <= '0;
      vend        <= 1'b0;
      nickel_out  <= 1'b0;
      dime_out    <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      vend        <= 1'b0;
      nickel_out  <= 1'b0;
      dime_out    <= 1'b0;
      coin_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (credit >= PRICE_C) begin
            // Vend decision edge. Any coin arriving on this edge goes to the chute.
            vend        <= 1'b1;
            credit      <= credit - PRICE_C;
            coin_reject <= any_coin;
            if (credit != PRICE_C) begin
              state <= CHANGE;
              busy  <= 1'b1;
            end
          end else begin
            credit      <= post_credit;
            coin_reject <= over;
            // The refund test uses post-coin credit, so a refund takes priority
            // over a coin that would have reached PRICE on the same edge.
            if (refund && (post_credit != '0)) begin
              state <= CHANGE;
              busy  <= 1'b1;
            end
          end
        end
        CHANGE: begin
          coin_reject <= any_coin;
          if (gap != '0) begin
            gap <= gap - 4'd1;
          end else if (credit >= DIME_C) begin
            dime_out <= 1'b1;
            credit   <= credit - DIME_C;
            gap      <= GAP_C;
          end else if (credit >= NICKEL_C) begin
            nickel_out <= 1'b1;
            credit     <= credit - NICKEL_C;
            gap        <= GAP_C;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_change_fsm.sv
// Bench for vend_change_fsm. Two instances share one stimulus stream:
// instance 0 uses PRICE=30/GAP=1 and instance 1 uses PRICE=95/GAP=0.
// A payout-schedule model predicts every output on every cycle.
module tb_vend_change_fsm;

  logic clk = 1'b0;
  logic reset, nickel, dime, quarter, refund;

  logic [1:0]      d_vend, d_nout, d_dout, d_rej, d_busy;
  logic [1:0][7:0] d_credit;

  localparam int P_PRICE [2] = '{30, 95};
  localparam int P_MAX   [2] = '{95, 95};
  localparam int P_GAP   [2] = '{1, 0};

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: the credit and the position within a precomputed payout schedule
  int m_credit [2];
  int m_t      [2];
  int m_len    [2];
  int m_nd     [2];
  bit m_active [2];
  bit e_vend [2], e_nout [2], e_dout [2], e_rej [2];

  always #5 clk = ~clk;

  vend_change_fsm #(.PRICE(30), .MAX_CREDIT(95), .CREDIT_W(8), .GAP(1)) dut_a (
    .clk(clk), .reset(reset), .nickel(nickel), .dime(dime), .quarter(quarter),
    .refund(refund), .vend(d_vend[0]), .nickel_out(d_nout[0]), .dime_out(d_dout[0]),
    .coin_reject(d_rej[0]), .busy(d_busy[0]), .credit(d_credit[0]));

  vend_change_fsm #(.PRICE(95), .MAX_CREDIT(95), .CREDIT_W(8), .GAP(0)) dut_b (
    .clk(clk), .reset(reset), .nickel(nickel), .dime(dime), .quarter(quarter),
    .refund(refund), .vend(d_vend[1]), .nickel_out(d_nout[1]), .dime_out(d_dout[1]),
    .coin_reject(d_rej[1]), .busy(d_busy[1]), .credit(d_credit[1]));

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_credit[i] = 0; m_t[i] = 0; m_len[i] = 0; m_nd[i] = 0; m_active[i] = 1'b0;
      e_vend[i] = 1'b0; e_nout[i] = 1'b0; e_dout[i] = 1'b0; e_rej[i] = 1'b0;
    end
  endtask

  // Greedy payout: all dimes, then at most one nickel. Each coin is followed by
  // GAP quiet cycles, and one final cycle returns to idle.
  task automatic start_payout(input int i);
    int nn;
    m_nd[i]     = m_credit[i] / 10;
    nn          = (m_credit[i] % 10) / 5;
    m_len[i]    = (m_nd[i] + nn) * (1 + P_GAP[i]) + 1;
    m_t[i]      = 0;
    m_active[i] = 1'b1;
  endtask

  // Predict the effect of the next rising edge using the current inputs
  task automatic model_step(input int i);
    int coins, per, k;
    bit anyc;
    coins = 5 * int'(nickel) + 10 * int'(dime) + 25 * int'(quarter);
    anyc  = nickel | dime | quarter;
    per   = 1 + P_GAP[i];
    e_vend[i] = 1'b0; e_nout[i] = 1'b0; e_dout[i] = 1'b0; e_rej[i] = 1'b0;
    if (m_active[i]) begin
      e_rej[i] = anyc;
      if (m_t[i] < m_len[i] - 1 && (m_t[i] % per) == 0) begin
        k = m_t[i] / per;
        if (k < m_nd[i]) begin e_dout[i] = 1'b1; m_credit[i] -= 10; end
        else             begin e_nout[i] = 1'b1; m_credit[i] -= 5;  end
      end
      m_t[i]++;
      if (m_t[i] == m_len[i]) m_active[i] = 1'b0;
    end else if (m_credit[i] >= P_PRICE[i]) begin
      e_vend[i]    = 1'b1;
      e_rej[i]     = anyc;
      m_credit[i] -= P_PRICE[i];
      if (m_credit[i] > 0) start_payout(i);
    end else begin
      if (m_credit[i] + coins > P_MAX[i]) e_rej[i] = 1'b1;
      else m_credit[i] += coins;
      if (refund && m_credit[i] > 0) start_payout(i);
    end
  endtask

  // Check every output of both instances against the model, just after each edge
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("vend[%0d]", i),        int'(d_vend[i]),   int'(e_vend[i]));
      chk($sformatf("nickel_out[%0d]", i),  int'(d_nout[i]),   int'(e_nout[i]));
      chk($sformatf("dime_out[%0d]", i),    int'(d_dout[i]),   int'(e_dout[i]));
      chk($sformatf("coin_reject[%0d]", i), int'(d_rej[i]),    int'(e_rej[i]));
      chk($sformatf("busy[%0d]", i),        int'(d_busy[i]),   int'(m_active[i]));
      chk($sformatf("credit[%0d]", i),      int'(d_credit[i]), m_credit[i]);
    end
  end

  // One clock edge with the given inputs; returns just after the falling edge
  task automatic cyc(input bit n, input bit d, input bit q, input bit r);
    nickel = n; dime = d; quarter = q; refund = r;
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0; refund = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(0, 0, 0, 0);
  endtask

  // Asynchronous reset between edges; outputs must clear without waiting for a clock
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s async outs[%0d]", tag, i),
          int'({d_vend[i], d_nout[i], d_dout[i], d_rej[i], d_busy[i]}), 0);
      chk($sformatf("%s async credit[%0d]", tag, i), int'(d_credit[i]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; nickel = 1'b0; dime = 1'b0; quarter = 1'b0; refund = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset credit", int'(d_credit[0]), 0);
    chk("reset busy", int'(d_busy[0]), 0);
    reset = 1'b0;

    // Three dimes reach the price exactly, so the item vends and no change is paid
    cyc(0, 1, 0, 0); chk("t1 credit 10", int'(d_credit[0]), 10);
    cyc(0, 1, 0, 0); chk("t1 credit 20", int'(d_credit[0]), 20);
    cyc(0, 1, 0, 0); chk("t1 credit 30", int'(d_credit[0]), 30);
    cyc(0, 0, 0, 0); chk("t1 vend", int'(d_vend[0]), 1);
    chk("t1 credit 0", int'(d_credit[0]), 0);
    chk("t1 busy", int'(d_busy[0]), 0);
    idle(3);
    do_reset("t1");

    // Two quarters give a vend and two paced dimes of change
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); chk("t2 credit 50", int'(d_credit[0]), 50);
    cyc(0, 0, 0, 0); chk("t2 vend", int'(d_vend[0]), 1);
    chk("t2 credit 20", int'(d_credit[0]), 20); chk("t2 busy", int'(d_busy[0]), 1);
    cyc(0, 0, 0, 0); chk("t2 dime e4", int'(d_dout[0]), 1);
    cyc(0, 0, 0, 0); chk("t2 gap e5", int'(d_dout[0]), 0);
    cyc(0, 0, 0, 0); chk("t2 dime e6", int'(d_dout[0]), 1);
    cyc(0, 0, 0, 0); chk("t2 busy e7", int'(d_busy[0]), 1);
    cyc(0, 0, 0, 0); chk("t2 busy e8", int'(d_busy[0]), 0);
    chk("t2 credit end", int'(d_credit[0]), 0);
    do_reset("t2");

    // Simultaneous coins are summed
    cyc(1, 1, 1, 0); chk("t3 credit 40", int'(d_credit[0]), 40);
    cyc(0, 0, 0, 0); chk("t3 vend", int'(d_vend[0]), 1);
    chk("t3 credit 10", int'(d_credit[0]), 10);
    cyc(0, 0, 0, 0); chk("t3 dime", int'(d_dout[0]), 1);
    idle(2); chk("t3 done", int'(d_busy[0]), 0);
    do_reset("t3");

    // A coin on the vend edge is rejected, and so is a coin inserted during payout
    cyc(0, 0, 1, 0); cyc(1, 1, 1, 0); chk("t4 credit 65", int'(d_credit[0]), 65);
    cyc(0, 0, 1, 0); chk("t4 vend", int'(d_vend[0]), 1);
    chk("t4 vend-edge reject", int'(d_rej[0]), 1);
    chk("t4 credit 35", int'(d_credit[0]), 35);
    cyc(0, 0, 0, 0); chk("t4 first dime", int'(d_dout[0]), 1);
    cyc(0, 0, 1, 0); chk("t4 change reject", int'(d_rej[0]), 1);
    chk("t4 credit held", int'(d_credit[0]), 25);
    idle(7); chk("t4 done", int'(d_busy[0]), 0);
    do_reset("t4");

    // Refund of 15: a dime, then a nickel. Instance 1 (GAP=0) pays the same coins back to back.
    cyc(1, 1, 0, 0); chk("t5 credit 15", int'(d_credit[0]), 15);
    cyc(0, 0, 0, 1); chk("t5 no vend", int'(d_vend[0]), 0);
    chk("t5 busy", int'(d_busy[0]), 1);
    cyc(0, 0, 0, 0); chk("t5 dime k+1", int'(d_dout[0]), 1);
    cyc(0, 0, 1, 0); chk("t5 reject", int'(d_rej[0]), 1);
    chk("t5 credit 5", int'(d_credit[0]), 5);
    chk("t5 b nickel", int'(d_nout[1]), 1);
    cyc(0, 0, 0, 0); chk("t5 nickel k+3", int'(d_nout[0]), 1);
    idle(2); chk("t5 done", int'(d_busy[0]), 0);
    do_reset("t5");

    // A refund wins over a coin that reaches the price on the same edge; a refund with no credit is ignored
    cyc(0, 0, 0, 1); chk("t6 zero refund", int'(d_busy[0]), 0);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1); chk("t6 no vend", int'(d_vend[0]), 0);
    chk("t6 credit 30", int'(d_credit[0]), 30); chk("t6 busy", int'(d_busy[0]), 1);
    idle(7); chk("t6 done", int'(d_busy[0]), 0);
    do_reset("t6");

    // Overflow on instance 1: 80 + 25 > 95 rejects the coin, and 95 exactly is accepted
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(1, 0, 0, 0);
    chk("t7 b credit 80", int'(d_credit[1]), 80);
    cyc(0, 0, 1, 0); chk("t7 b reject", int'(d_rej[1]), 1);
    chk("t7 b credit held", int'(d_credit[1]), 80);
    cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); chk("t7 b credit 95", int'(d_credit[1]), 95);
    cyc(0, 0, 0, 0); chk("t7 b vend", int'(d_vend[1]), 1);
    chk("t7 b credit 0", int'(d_credit[1]), 0);
    idle(8);
    do_reset("t7");

    // Reset after the first dime of a 20c refund truncates the payout
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0); chk("t8 first dime", int'(d_dout[0]), 1);
    do_reset("t8");
    idle(5);
    chk("t8 credit", int'(d_credit[0]), 0);
    chk("t8 busy", int'(d_busy[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
